// File: rtl/user_proto_pkg.sv
// user_proto_pkg: framing constants, field widths, error codes and TX states for the "!"-framed SDRAM protocol
package user_proto_pkg;
    localparam int LEN_BITS  = 24;
    localparam int ADDR_BITS = 32;

    localparam logic [7:0] CMD_HDR     = 8'h21;
    localparam logic [7:0] CMD_RD      = 8'h52;
    localparam logic [7:0] CMD_WR      = 8'h57;
    localparam logic [7:0] CMD_VERSION = 8'h56;
    localparam logic [7:0] RSP_WR_ACK  = 8'h77;
    localparam logic [7:0] RSP_NAK     = 8'h3F;
    localparam logic [7:0] RSP_ABORT   = 8'h40;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_ECHO       = 2'd1,
        ERR_UNEXPECTED = 2'd2,
        ERR_TIMEOUT    = 2'd3
    } err_e;

    // Ordered so that the fixed header bytes advance by simple increment.
    typedef enum logic [3:0] {
        S_IDLE, S_HDR, S_CMD, S_L2, S_L1, S_L0, S_A3, S_A2, S_A1, S_A0, S_WDATA, S_RESP
    } tx_state_e;
endpackage

// File: rtl/user_command_issuer_if.sv
// user_command_issuer_if: host-side request, write payload, read data and status bundle
interface user_command_issuer_if;
    import user_proto_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic [7:0]           req_cmd;
    logic [LEN_BITS-1:0]  req_len;
    logic [ADDR_BITS-1:0] req_addr;
    logic [7:0]           wr_data;
    logic                 wr_valid;
    logic                 wr_ready;
    logic [7:0]           rd_data;
    logic                 rd_valid;
    logic                 done;
    logic                 error;
    logic [1:0]           err_code;

    modport master (
        output req_valid, req_cmd, req_len, req_addr, wr_data, wr_valid,
        input  req_ready, wr_ready, rd_data, rd_valid, done, error, err_code
    );

    modport slave (
        input  req_valid, req_cmd, req_len, req_addr, wr_data, wr_valid,
        output req_ready, wr_ready, rd_data, rd_valid, done, error, err_code
    );
endinterface

// File: rtl/user_response_checker.sv
// user_response_checker: validates the echo, forwards read/version bytes, and raises done/error/timeout
module user_response_checker
    import user_proto_pkg::*;
#(
    parameter int VERSION_LEN    = 8,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_i,
    input  logic                cmd_sent_i,
    input  logic [7:0]          cmd_i,
    input  logic [LEN_BITS-1:0] len_i,
    input  logic [7:0]          uart_rxd_i,
    input  logic                uart_rxd_strobe_i,
    output logic [7:0]          rd_data_o,
    output logic                rd_valid_o,
    output logic                done_o,
    output logic                error_o,
    output logic [1:0]          err_code_o
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic                armed_q, armed_d, listen_q, listen_d, echo_q, echo_d;
    logic [LEN_BITS-1:0] cnt_q, cnt_d, init;
    logic [TW-1:0]       tmr_q, tmr_d;
    logic [7:0]          rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d, done_q, done_d, error_q, error_d;
    err_e                err_q, err_d;
    logic                known, rx;

    assign known = cmd_i == CMD_RD || cmd_i == CMD_WR || cmd_i == CMD_VERSION;
    assign init  = cmd_i == CMD_VERSION ? LEN_BITS'(VERSION_LEN) : len_i;
    assign rx    = uart_rxd_strobe_i && armed_q && (listen_q || cmd_sent_i);

    // Echo check, data forwarding and idle-timeout for the frame in flight.
    always_comb begin
        armed_d    = armed_q;
        listen_d   = listen_q;
        echo_d     = echo_q;
        cnt_d      = cnt_q;
        tmr_d      = tmr_q;
        rd_data_d  = rd_data_q;
        err_d      = err_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        error_d    = 1'b0;
        if (start_i) begin
            armed_d  = 1'b1;
            listen_d = 1'b0;
            echo_d   = 1'b0;
            tmr_d    = '0;
            err_d    = ERR_NONE;
        end else if (armed_q) begin
            tmr_d    = tmr_q + 1'b1;
            listen_d = listen_q || cmd_sent_i;
            if (rx) begin
                tmr_d = '0;
                if (!echo_q) begin
                    echo_d = 1'b1;
                    cnt_d  = init;
                    if (!known) begin
                        done_d  = uart_rxd_i == RSP_NAK;
                        error_d = !done_d;
                        err_d   = done_d ? err_q : ERR_ECHO;
                    end else if (uart_rxd_i != cmd_i) begin
                        error_d = 1'b1;
                        err_d   = (uart_rxd_i == RSP_NAK || uart_rxd_i == RSP_ABORT) ? ERR_UNEXPECTED : ERR_ECHO;
                    end else begin
                        done_d = cmd_i != CMD_WR && init == '0;
                    end
                end else if (cmd_i == CMD_WR) begin
                    done_d  = uart_rxd_i == RSP_WR_ACK;
                    error_d = !done_d;
                    err_d   = done_d ? err_q : ERR_UNEXPECTED;
                end else begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = uart_rxd_i;
                    cnt_d      = cnt_q - 1'b1;
                    done_d     = cnt_q == LEN_BITS'(1);
                end
            end else if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
                error_d = 1'b1;
                err_d   = ERR_TIMEOUT;
            end
            if (done_d || error_d) armed_d = 1'b0;
        end
    end

    // Response-tracking state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            armed_q    <= 1'b0;
            listen_q   <= 1'b0;
            echo_q     <= 1'b0;
            cnt_q      <= '0;
            tmr_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_q      <= ERR_NONE;
        end else begin
            armed_q    <= armed_d;
            listen_q   <= listen_d;
            echo_q     <= echo_d;
            cnt_q      <= cnt_d;
            tmr_q      <= tmr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_q      <= err_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign done_o     = done_q;
    assign error_o    = error_q;
    assign err_code_o = err_q;
endmodule

// File: rtl/user_command_issuer.sv
// user_command_issuer: serialises one request as a "!"-framed command to the UART and tracks the device response
module user_command_issuer
    import user_proto_pkg::*;
#(
    parameter int VERSION_LEN    = 8,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                 clk,
    input  logic                 reset,
    user_command_issuer_if.slave host,
    output logic [7:0]           uart_txd,
    output logic                 uart_txd_strobe,
    input  logic                 uart_txd_ready,
    input  logic [7:0]           uart_rxd,
    input  logic                 uart_rxd_strobe
);
    tx_state_e            state_q, state_d;
    logic [7:0]           cmd_q, cmd_d, tx_byte;
    logic [LEN_BITS-1:0]  len_q, len_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 gap_q, start, fin, send, rw;

    assign fin   = host.done || host.error;
    assign start = state_q == S_IDLE && host.req_valid;
    assign rw    = cmd_q == CMD_RD || cmd_q == CMD_WR;
    // The gap flag forces an idle cycle after every strobe; reset and completion silence tx immediately.
    assign send  = !reset && !fin && uart_txd_ready && !gap_q && state_q != S_IDLE && state_q != S_RESP &&
                   (state_q != S_WDATA || host.wr_valid);

    assign uart_txd        = send ? tx_byte : 8'h00;
    assign uart_txd_strobe = send;
    assign host.wr_ready   = send && state_q == S_WDATA;
    assign host.req_ready  = state_q == S_IDLE;

    // Byte presented for the current transmit state.
    always_comb begin
        tx_byte = 8'h00;
        case (state_q)
            S_HDR:   tx_byte = CMD_HDR;
            S_CMD:   tx_byte = cmd_q;
            S_L2:    tx_byte = len_q[23:16];
            S_L1:    tx_byte = len_q[15:8];
            S_L0:    tx_byte = len_q[7:0];
            S_A3:    tx_byte = addr_q[31:24];
            S_A2:    tx_byte = addr_q[23:16];
            S_A1:    tx_byte = addr_q[15:8];
            S_A0:    tx_byte = addr_q[7:0];
            S_WDATA: tx_byte = host.wr_data;
            default: tx_byte = 8'h00;
        endcase
    end

    // Frame sequencing: latch on accept, advance per sent byte, return to idle on completion.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        len_d   = len_q;
        addr_d  = addr_q;
        if (start) begin
            state_d = S_HDR;
            cmd_d   = host.req_cmd;
            len_d   = host.req_len;
            addr_d  = host.req_addr;
        end else if (state_q != S_IDLE && fin) begin
            state_d = S_IDLE;
        end else if (send) begin
            case (state_q)
                S_CMD:   state_d = rw ? S_L2 : S_RESP;
                S_A0:    state_d = (cmd_q == CMD_WR && len_q != '0) ? S_WDATA : S_RESP;
                S_WDATA: begin
                    len_d   = len_q - 1'b1;
                    state_d = len_q == LEN_BITS'(1) ? S_RESP : S_WDATA;
                end
                default: state_d = tx_state_e'(state_q + 4'd1);
            endcase
        end
    end

    // Transmit-side state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            gap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            gap_q   <= send;
        end
    end

    user_response_checker #(
        .VERSION_LEN   (VERSION_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_checker (
        .clk              (clk),
        .reset            (reset),
        .start_i          (start),
        .cmd_sent_i       (send && state_q == S_CMD),
        .cmd_i            (cmd_q),
        .len_i            (len_q),
        .uart_rxd_i       (uart_rxd),
        .uart_rxd_strobe_i(uart_rxd_strobe),
        .rd_data_o        (host.rd_data),
        .rd_valid_o       (host.rd_valid),
        .done_o           (host.done),
        .error_o          (host.error),
        .err_code_o       (host.err_code)
    );
endmodule
